// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared async-FIFO helpers for Gray/binary conversion, bit
//               counting, pointer width and synchroniser depth legality.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Helpers work on a wide zero-extended vector so callers of any width can share them
    localparam int c_max_w = 32;

    function automatic int ptr_width(input int addrsize);
        return addrsize + 1;
    endfunction

    function automatic logic [c_max_w-1:0] bin2gray(input logic [c_max_w-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [c_max_w-1:0] gray2bin(input logic [c_max_w-1:0] g);
        logic [c_max_w-1:0] b;
        b[c_max_w-1] = g[c_max_w-1];
        for (int i = c_max_w - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int popcount(input logic [c_max_w-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < c_max_w; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    function automatic bit sync_stages_legal(input int n);
        return (n >= 2) && (n <= 4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_sync_n.sv
`default_nettype none
// ============================================================================
// Module      : gray_sync_n
// Description : Plain N-stage flop chain for bringing a Gray pointer across
//               a clock domain boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_sync_n #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_sync [STAGES];

    // Nothing but wires between stages so each flop has a full period to resolve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/wptr_full_sync.sv
`default_nettype none
// ============================================================================
// Module      : wptr_full_sync
// Description : Async FIFO write-domain control: read-pointer synchroniser,
//               write pointer, full/almost-full/count and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module wptr_full_sync
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                w_clk,
    input  logic                w_rst_n,
    input  logic                w_inc,
    input  logic                w_err_clr,
    input  logic [ADDRSIZE:0]   rptr_gray,
    output logic [ADDRSIZE:0]   wptr_gray,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                w_full,
    output logic                w_afull,
    output logic [ADDRSIZE:0]   w_count,
    output logic                w_ovf,
    output logic                w_gray_err
);

    localparam int PTR_W = ptr_width(ADDRSIZE);
    localparam logic [PTR_W-1:0] c_afull_lvl = PTR_W'(AFULL_LEVEL);

    if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync_stages
        $error("wptr_full_sync: SYNC_STAGES must be in 2..4");
    end
    if ((AFULL_LEVEL < 1) || (AFULL_LEVEL > (2 ** ADDRSIZE))) begin : g_bad_afull_level
        $error("wptr_full_sync: AFULL_LEVEL must be in 1..2**ADDRSIZE");
    end
    if (ADDRSIZE < 2) begin : g_bad_addrsize
        $error("wptr_full_sync: ADDRSIZE must be at least 2");
    end

    logic [PTR_W-1:0] r_wbin;
    logic [PTR_W-1:0] r_rq_prev;
    logic [PTR_W-1:0] w_rq_gray;
    logic [PTR_W-1:0] w_rbin;
    logic [PTR_W-1:0] w_wbin_next;
    logic [PTR_W-1:0] w_wgray_next;
    logic [PTR_W-1:0] w_full_gray;
    logic [PTR_W-1:0] w_fill_next;
    logic             w_accept;
    logic             w_ovf_set;
    logic             w_gerr_set;

    gray_sync_n #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk   (w_clk),
        .rst_n (w_rst_n),
        .d     (rptr_gray),
        .q     (w_rq_gray)
    );

    assign w_rbin       = PTR_W'(gray2bin(c_max_w'(w_rq_gray)));
    assign w_accept     = w_inc & ~w_full;
    assign w_wbin_next  = r_wbin + PTR_W'(w_accept);
    assign w_wgray_next = PTR_W'(bin2gray(c_max_w'(w_wbin_next)));
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted
    assign w_full_gray  = {~w_rq_gray[ADDRSIZE:ADDRSIZE-1], w_rq_gray[ADDRSIZE-2:0]};
    assign w_fill_next  = w_wbin_next - w_rbin;
    assign w_ovf_set    = w_inc & w_full;
    assign w_gerr_set   = popcount(c_max_w'(w_rq_gray ^ r_rq_prev)) > 1;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wbin     <= '0;
            wptr_gray  <= '0;
            r_rq_prev  <= '0;
            w_full     <= 1'b0;
            w_afull    <= 1'b0;
            w_count    <= '0;
            w_ovf      <= 1'b0;
            w_gray_err <= 1'b0;
        end else begin
            r_wbin    <= w_wbin_next;
            wptr_gray <= w_wgray_next;
            r_rq_prev <= w_rq_gray;
            w_full    <= (w_wgray_next == w_full_gray);
            w_afull   <= (w_fill_next >= c_afull_lvl);
            w_count   <= w_fill_next;
            // A new error in the clearing cycle must not be lost
            if (w_ovf_set) begin
                w_ovf <= 1'b1;
            end else if (w_err_clr) begin
                w_ovf <= 1'b0;
            end
            if (w_gerr_set) begin
                w_gray_err <= 1'b1;
            end else if (w_err_clr) begin
                w_gray_err <= 1'b0;
            end
        end
    end

    assign waddr = r_wbin[ADDRSIZE-1:0];

endmodule
`default_nettype wire

// File: tb/tb_wptr_full_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_wptr_full_sync
// Description : Randomised self-checking bench for wptr_full_sync against an
//               occupancy-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wptr_full_sync;

    logic       w_clk;
    logic       w_rst_n;
    logic       w_inc;
    logic       w_err_clr;
    logic [4:0] rptr_gray;
    logic [4:0] wptr_gray;
    logic [3:0] waddr;
    logic       w_full;
    logic       w_afull;
    logic [4:0] w_count;
    logic       w_ovf;
    logic       w_gray_err;

    int n_checks = 0;
    int n_errors = 0;

    wptr_full_sync #(
        .ADDRSIZE    (4),
        .SYNC_STAGES (2),
        .AFULL_LEVEL (12)
    ) dut (
        .w_clk      (w_clk),
        .w_rst_n    (w_rst_n),
        .w_inc      (w_inc),
        .w_err_clr  (w_err_clr),
        .rptr_gray  (rptr_gray),
        .wptr_gray  (wptr_gray),
        .waddr      (waddr),
        .w_full     (w_full),
        .w_afull    (w_afull),
        .w_count    (w_count),
        .w_ovf      (w_ovf),
        .w_gray_err (w_gray_err)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    // Model: writes counted as an integer lap position, read pointer seen two edges late
    int m_wpos, m_count, s0, s1, s2;
    bit m_full, m_afull, m_ovf, m_gerr;

    function automatic int g2b(input int g);
        int b;
        b = g;
        for (int s = 1; s < 5; s++) b = b ^ (g >> s);
        return b & 31;
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & 31;
    endfunction

    task automatic model_reset();
        m_wpos = 0; m_count = 0; s0 = 0; s1 = 0; s2 = 0;
        m_full = 0; m_afull = 0; m_ovf = 0; m_gerr = 0;
    endtask

    task automatic model_edge(input bit inc, input bit clr, input int rg);
        bit gset;
        bit oset;
        oset   = inc && m_full;
        gset   = $countones(s1 ^ s2) > 1;
        if (inc && !m_full) m_wpos = (m_wpos + 1) % 32;
        m_count = (m_wpos - g2b(s1) + 32) % 32;
        m_full  = (m_count == 16);
        m_afull = (m_count >= 12);
        m_ovf   = oset ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_gerr  = gset ? 1'b1 : (clr ? 1'b0 : m_gerr);
        s2 = s1; s1 = s0; s0 = rg;
    endtask

    task automatic step(input bit inc, input bit clr, input int rg);
        w_inc = inc; w_err_clr = clr; rptr_gray = rg[4:0];
        @(posedge w_clk);
        model_edge(inc, clr, rg);
        #1;
    endtask

    task automatic do_reset();
        w_rst_n = 1'b0; w_inc = 1'b0; w_err_clr = 1'b0; rptr_gray = '0;
        model_reset();
        repeat (2) @(negedge w_clk);
        w_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        #2 w_rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({wptr_gray, waddr, w_full, w_afull, w_count, w_ovf, w_gray_err} !== 19'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got gray=%b addr=%0d full=%b afull=%b cnt=%0d ovf=%b gerr=%b, expected all 0",
                     wptr_gray, waddr, w_full, w_afull, w_count, w_ovf, w_gray_err);
        end
        @(negedge w_clk);
        w_rst_n = 1'b1;
        step(1, 0, 0);
        n_checks++;
        if (waddr !== 4'd1 || wptr_gray !== 5'b00001) begin
            n_errors++;
            $display("FAIL first_write: got addr=%0d gray=%b, expected addr=1 gray=00001", waddr, wptr_gray);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, 0);
            n_checks++;
            if (w_count !== 5'(m_count) || w_afull !== m_afull || w_full !== m_full) begin
                n_errors++;
                $display("FAIL fill_w%0d: got cnt=%0d afull=%b full=%b, expected cnt=%0d afull=%b full=%b",
                         i, w_count, w_afull, w_full, m_count, m_afull, m_full);
            end
            if (i == 12) begin
                n_checks++;
                if (w_afull !== 1'b1 || w_count !== 5'd12) begin
                    n_errors++;
                    $display("FAIL afull_at_12: got afull=%b cnt=%0d, expected afull=1 cnt=12", w_afull, w_count);
                end
            end
        end
        n_checks++;
        if (w_full !== 1'b1 || w_count !== 5'd16 || waddr !== 4'd0 || wptr_gray !== 5'b11000) begin
            n_errors++;
            $display("FAIL full_at_16: got full=%b cnt=%0d addr=%0d gray=%b, expected full=1 cnt=16 addr=0 gray=11000",
                     w_full, w_count, waddr, wptr_gray);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            n_checks++;
            if (wptr_gray !== 5'b11000 || w_ovf !== 1'b1 || w_full !== 1'b1) begin
                n_errors++;
                $display("FAIL ovf_write%0d: got gray=%b ovf=%b full=%b, expected gray=11000 ovf=1 full=1",
                         i, wptr_gray, w_ovf, w_full);
            end
        end
        step(0, 0, 0);
        step(0, 0, 0);
        n_checks++;
        if (w_ovf !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_sticky: got %b expected 1", w_ovf);
        end
        step(1, 1, 0);
        n_checks++;
        if (w_ovf !== 1'b1 || w_ovf !== m_ovf) begin
            n_errors++;
            $display("FAIL ovf_set_beats_clr: got %b expected 1", w_ovf);
        end
        step(0, 1, 0);
        n_checks++;
        if (w_ovf !== 1'b0 || w_ovf !== m_ovf) begin
            n_errors++;
            $display("FAIL ovf_clear: got %b expected 0", w_ovf);
        end
    endtask

    task automatic test_drain();
        bit exp_full [3] = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 6);
            n_checks++;
            if (w_full !== exp_full[k] || w_full !== m_full || w_afull !== 1'b1) begin
                n_errors++;
                $display("FAIL drain_edge%0d: got full=%b afull=%b, expected full=%b afull=1",
                         k, w_full, w_afull, exp_full[k]);
            end
        end
        n_checks++;
        if (w_count !== 5'd12) begin
            n_errors++;
            $display("FAIL drain_count: got %0d expected 12", w_count);
        end
    endtask

    task automatic test_stream();
        int  rd;
        int  written;
        int  cycles;
        bit  wrapped;
        bit  inc;
        logic [4:0] prev_gray;
        do_reset();
        rd = 0; written = 0; cycles = 0; wrapped = 0; prev_gray = '0;
        while (written < 40 && cycles < 300) begin
            if (((m_wpos - rd + 32) % 32) != 0 && $urandom_range(0, 1) == 1) rd = (rd + 1) % 32;
            inc = $urandom_range(0, 3) != 0;
            if (inc && !m_full) written++;
            step(inc, 0, b2g(rd));
            cycles++;
            if (prev_gray == 5'b10000 && wptr_gray == 5'b00000) wrapped = 1;
            prev_gray = wptr_gray;
            n_checks++;
            if (w_count !== 5'(m_count) || w_full !== m_full || w_afull !== m_afull ||
                wptr_gray !== 5'(b2g(m_wpos)) || waddr !== 4'(m_wpos % 16) || w_gray_err !== 1'b0) begin
                n_errors++;
                $display("FAIL stream_c%0d: got cnt=%0d full=%b afull=%b gray=%b addr=%0d gerr=%b, expected cnt=%0d full=%b afull=%b gray=%b addr=%0d gerr=0",
                         cycles, w_count, w_full, w_afull, wptr_gray, waddr, w_gray_err,
                         m_count, m_full, m_afull, 5'(b2g(m_wpos)), m_wpos % 16);
            end
        end
        n_checks++;
        if (written < 40 || !wrapped) begin
            n_errors++;
            $display("FAIL stream_wrap: got written=%0d wrapped=%b, expected written=40 wrapped=1", written, wrapped);
        end
    endtask

    task automatic test_gray_err();
        bit exp_err [3] = '{1'b0, 1'b0, 1'b1};
        do_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 3);
            n_checks++;
            if (w_gray_err !== exp_err[k] || w_gray_err !== m_gerr) begin
                n_errors++;
                $display("FAIL gerr_edge%0d: got %b expected %b", k, w_gray_err, exp_err[k]);
            end
        end
        for (int k = 0; k < 4; k++) step(1, 0, 3);
        n_checks++;
        if (w_gray_err !== 1'b1 || w_count !== 5'(m_count)) begin
            n_errors++;
            $display("FAIL gerr_sticky: got gerr=%b cnt=%0d, expected gerr=1 cnt=%0d", w_gray_err, w_count, m_count);
        end
        step(0, 1, 3);
        n_checks++;
        if (w_gray_err !== 1'b0) begin
            n_errors++;
            $display("FAIL gerr_clear: got %b expected 0", w_gray_err);
        end
    endtask

    initial begin
        w_rst_n = 1'b0; w_inc = 1'b0; w_err_clr = 1'b0; rptr_gray = '0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_stream();
        test_gray_err();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
